// File: rtl/packet_sink.sv
// Ejection endpoint: reassembles head/body/tail flits, checks framing, records per-packet latency.
// Latency: completion stats are registered, visible the cycle after the tail handshake.
// Backpressure: flit_ready drops for exactly one DRAIN cycle after each good packet, else flits are always sunk.
module packet_sink #(
    parameter int MAX_CYCLE_WIDTH = 5,
    parameter int SRC_WIDTH       = 2,
    parameter int MAX_PKT_FLITS   = 4,
    parameter int COUNT_WIDTH     = 8,
    parameter int SUM_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [MAX_CYCLE_WIDTH-1:0] current_cycle,
    input  logic                       flit_valid,
    output logic                       flit_ready,
    input  logic                       flit_head,
    input  logic                       flit_tail,
    input  logic [SRC_WIDTH-1:0]       flit_src,
    input  logic [MAX_CYCLE_WIDTH-1:0] flit_timestamp,
    output logic [1:0]                 state,
    output logic [COUNT_WIDTH-1:0]     packets_received,
    output logic [MAX_CYCLE_WIDTH-1:0] last_latency,
    output logic [SRC_WIDTH-1:0]       last_src,
    output logic [SUM_WIDTH-1:0]       latency_sum,
    output logic                       error
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_BODY  = 2'b01,
        S_DRAIN = 2'b10,
        S_ERROR = 2'b11
    } state_t;

    // One spare count value so the increment past MAX_PKT_FLITS never wraps.
    localparam int CNT_W = $clog2(MAX_PKT_FLITS + 2);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PKT_FLITS);

    state_t                     state_q, state_d;
    logic [MAX_CYCLE_WIDTH-1:0] ts_q, ts_d;
    logic [SRC_WIDTH-1:0]       src_q, src_d;
    logic [CNT_W-1:0]           flit_cnt_q, flit_cnt_d;
    logic [CNT_W-1:0]           cnt_inc;
    logic [COUNT_WIDTH-1:0]     pkt_cnt_q, pkt_cnt_d;
    logic [MAX_CYCLE_WIDTH-1:0] last_lat_q, last_lat_d;
    logic [SRC_WIDTH-1:0]       last_src_q, last_src_d;
    logic [SUM_WIDTH-1:0]       lat_sum_q, lat_sum_d;

    logic                       xfer;
    logic                       complete;
    logic [MAX_CYCLE_WIDTH-1:0] done_ts;
    logic [SRC_WIDTH-1:0]       done_src;
    logic [MAX_CYCLE_WIDTH-1:0] lat;
    logic [SUM_WIDTH:0]         sum_ext;

    assign flit_ready       = (state_q != S_DRAIN);
    assign xfer             = flit_valid & flit_ready;
    assign state            = state_q;
    assign error            = (state_q == S_ERROR);
    assign packets_received = pkt_cnt_q;
    assign last_latency     = last_lat_q;
    assign last_src         = last_src_q;
    assign latency_sum      = lat_sum_q;
    assign cnt_inc          = flit_cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        ts_d       = ts_q;
        src_d      = src_q;
        flit_cnt_d = flit_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        last_lat_d = last_lat_q;
        last_src_d = last_src_q;
        lat_sum_d  = lat_sum_q;
        complete   = 1'b0;
        done_ts    = ts_q;
        done_src   = src_q;

        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    if (flit_head) begin
                        ts_d       = flit_timestamp;
                        src_d      = flit_src;
                        flit_cnt_d = CNT_W'(1);
                        if (flit_tail) begin
                            // Single-flit packet: use the live header fields, not the latches.
                            complete = 1'b1;
                            done_ts  = flit_timestamp;
                            done_src = flit_src;
                            state_d  = S_DRAIN;
                        end else begin
                            state_d = S_BODY;
                        end
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_BODY: begin
                if (xfer) begin
                    if (flit_head) begin
                        state_d = S_ERROR;
                    end else if (flit_tail) begin
                        complete = 1'b1;
                        state_d  = S_DRAIN;
                    end else begin
                        flit_cnt_d = cnt_inc;
                        if (cnt_inc >= MAX_CNT) begin
                            state_d = S_ERROR;
                        end
                    end
                end
            end
            S_DRAIN: state_d = S_IDLE;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase

        // Modular subtraction makes the latency correct across current_cycle wrap.
        lat     = current_cycle - done_ts;
        sum_ext = {1'b0, lat_sum_q} + {{(SUM_WIDTH + 1 - MAX_CYCLE_WIDTH){1'b0}}, lat};

        if (complete) begin
            last_lat_d = lat;
            last_src_d = done_src;
            pkt_cnt_d  = pkt_cnt_q + COUNT_WIDTH'(1);
            lat_sum_d  = sum_ext[SUM_WIDTH] ? {SUM_WIDTH{1'b1}} : sum_ext[SUM_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ts_q       <= '0;
            src_q      <= '0;
            flit_cnt_q <= '0;
            pkt_cnt_q  <= '0;
            last_lat_q <= '0;
            last_src_q <= '0;
            lat_sum_q  <= '0;
        end else begin
            state_q    <= state_d;
            ts_q       <= ts_d;
            src_q      <= src_d;
            flit_cnt_q <= flit_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            last_lat_q <= last_lat_d;
            last_src_q <= last_src_d;
            lat_sum_q  <= lat_sum_d;
        end
    end

endmodule

// File: tb/tb_packet_sink.sv
// Randomized bench for packet_sink against a packet-level reference model.
module tb_packet_sink;

    localparam int MAXF = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] current_cycle = '0;
    logic       flit_valid = 1'b0;
    logic       flit_ready;
    logic       flit_head = 1'b0;
    logic       flit_tail = 1'b0;
    logic [1:0] flit_src = '0;
    logic [4:0] flit_timestamp = '0;
    logic [1:0] state;
    logic [7:0] packets_received;
    logic [4:0] last_latency;
    logic [1:0] last_src;
    logic [15:0] latency_sum;
    logic       error;

    packet_sink #(
        .MAX_CYCLE_WIDTH(5), .SRC_WIDTH(2), .MAX_PKT_FLITS(MAXF),
        .COUNT_WIDTH(8), .SUM_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset), .current_cycle(current_cycle),
        .flit_valid(flit_valid), .flit_ready(flit_ready),
        .flit_head(flit_head), .flit_tail(flit_tail),
        .flit_src(flit_src), .flit_timestamp(flit_timestamp),
        .state(state), .packets_received(packets_received),
        .last_latency(last_latency), .last_src(last_src),
        .latency_sum(latency_sum), .error(error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: packet in progress, drain pending, framing broken.
    bit m_err, m_drain, m_in_pkt;
    int m_nflits, m_ts, m_src;
    int m_count, m_sum, m_last_lat, m_last_src;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_err = 0; m_drain = 0; m_in_pkt = 0; m_nflits = 0; m_ts = 0; m_src = 0;
        m_count = 0; m_sum = 0; m_last_lat = 0; m_last_src = 0;
    endtask

    task automatic model_finish(input int cyc, input int ts, input int src);
        int lat;
        lat = (cyc - ts + 32) % 32;
        m_last_lat = lat;
        m_last_src = src;
        m_count = (m_count + 1) % 256;
        m_sum = (m_sum + lat > 65535) ? 65535 : m_sum + lat;
        m_in_pkt = 0;
        m_drain = 1;
    endtask

    task automatic model_step(input bit rst, input bit vld, input bit hd, input bit tl,
                              input int src, input int ts, input int cyc);
        if (rst) begin
            model_reset();
        end else if (m_drain) begin
            m_drain = 0;
        end else if (vld && !m_err) begin
            if (!m_in_pkt) begin
                if (!hd) m_err = 1;
                else if (tl) model_finish(cyc, ts, src);
                else begin
                    m_in_pkt = 1; m_nflits = 1; m_ts = ts; m_src = src;
                end
            end else begin
                if (hd) m_err = 1;
                else if (tl) model_finish(cyc, m_ts, m_src);
                else begin
                    m_nflits++;
                    if (m_nflits >= MAXF) m_err = 1;
                end
            end
        end
    endtask

    task automatic check_all();
        int exp_state;
        exp_state = m_err ? 3 : m_drain ? 2 : m_in_pkt ? 1 : 0;
        chk("state", 32'(state), 32'(exp_state));
        chk("flit_ready", 32'(flit_ready), 32'(!m_drain));
        chk("error", 32'(error), 32'(m_err));
        chk("packets_received", 32'(packets_received), 32'(m_count));
        chk("last_latency", 32'(last_latency), 32'(m_last_lat));
        chk("last_src", 32'(last_src), 32'(m_last_src));
        chk("latency_sum", 32'(latency_sum), 32'(m_sum));
    endtask

    // Called at a negedge: drive inputs for the next posedge, advance model, check after the edge.
    task automatic do_cycle(input bit rst, input bit vld, input bit hd, input bit tl,
                            input logic [1:0] src, input logic [4:0] ts, input logic [4:0] cyc);
        reset = rst; flit_valid = vld; flit_head = hd; flit_tail = tl;
        flit_src = src; flit_timestamp = ts; current_cycle = cyc;
        model_step(rst, vld, hd, tl, int'(src), int'(ts), int'(cyc));
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    logic [4:0] cyc;
    int g_len, g_pos;

    initial begin
        model_reset();
        cyc = '0;
        @(negedge clk);

        // Reset state
        do_cycle(1, 0, 0, 0, 0, 0, 0);
        chk("rst_state", 32'(state), 0);
        chk("rst_ready", 32'(flit_ready), 1);
        chk("rst_pkts", 32'(packets_received), 0);
        chk("rst_error", 32'(error), 0);

        // Single-flit packet ts=3 src=2 at cycle 7
        do_cycle(0, 1, 1, 1, 2'd2, 5'd3, 5'd7);
        chk("sf_lat", 32'(last_latency), 4);
        chk("sf_src", 32'(last_src), 2);
        chk("sf_pkts", 32'(packets_received), 1);
        chk("sf_state", 32'(state), 2);
        chk("sf_ready", 32'(flit_ready), 0);
        do_cycle(0, 1, 1, 1, 2'd1, 5'd0, 5'd8);
        chk("sf_idle", 32'(state), 0);
        chk("sf_drain_hold", 32'(packets_received), 1);

        // 3-flit packet with timestamp wrap
        do_cycle(0, 1, 1, 0, 2'd1, 5'd30, 5'd0);
        do_cycle(0, 1, 0, 0, 2'd3, 5'd11, 5'd1);
        do_cycle(0, 1, 0, 1, 2'd0, 5'd12, 5'd2);
        chk("wrap_lat", 32'(last_latency), 4);
        chk("wrap_src", 32'(last_src), 1);
        chk("wrap_sum", 32'(latency_sum), 8);
        do_cycle(0, 0, 0, 0, 0, 0, 5'd3);

        // Body flit while idle -> sticky error, later packet not counted
        do_cycle(0, 1, 0, 0, 2'd0, 5'd0, 5'd4);
        chk("err_flag", 32'(error), 1);
        chk("err_state", 32'(state), 3);
        chk("err_ready", 32'(flit_ready), 1);
        do_cycle(0, 1, 1, 1, 2'd3, 5'd1, 5'd5);
        do_cycle(0, 0, 0, 0, 0, 0, 5'd6);
        chk("err_pkts", 32'(packets_received), 2);

        // Over-length packet -> error on 4th flit
        do_cycle(1, 0, 0, 0, 0, 0, 0);
        do_cycle(0, 1, 1, 0, 2'd1, 5'd0, 5'd1);
        do_cycle(0, 1, 0, 0, 0, 0, 5'd2);
        do_cycle(0, 1, 0, 0, 0, 0, 5'd3);
        chk("len3_state", 32'(state), 1);
        do_cycle(0, 1, 0, 0, 0, 0, 5'd4);
        chk("len4_state", 32'(state), 3);
        do_cycle(0, 1, 0, 1, 0, 0, 5'd5);
        chk("len5_pkts", 32'(packets_received), 0);

        // Head inside a packet -> error
        do_cycle(1, 0, 0, 0, 0, 0, 0);
        do_cycle(0, 1, 1, 0, 2'd1, 5'd0, 5'd1);
        do_cycle(0, 1, 1, 1, 2'd1, 5'd0, 5'd2);
        chk("hib_state", 32'(state), 3);

        // Reset mid-packet with a flit presented
        do_cycle(1, 0, 0, 0, 0, 0, 0);
        do_cycle(0, 1, 1, 1, 2'd3, 5'd0, 5'd9);
        do_cycle(0, 0, 0, 0, 0, 0, 5'd10);
        do_cycle(0, 1, 1, 0, 2'd2, 5'd5, 5'd11);
        do_cycle(1, 1, 1, 0, 2'd2, 5'd5, 5'd12);
        chk("mid_rst_state", 32'(state), 0);
        chk("mid_rst_pkts", 32'(packets_received), 0);
        do_cycle(0, 1, 1, 1, 2'd2, 5'd10, 5'd13);
        chk("mid_rst_next", 32'(packets_received), 1);
        chk("mid_rst_lat", 32'(last_latency), 3);

        // Randomized traffic, mostly well-framed with occasional corruption and resets
        g_len = 1; g_pos = 0;
        for (int i = 0; i < 4000; i++) begin
            bit rst, vld, hd, tl, acc;
            logic [1:0] src;
            logic [4:0] ts;
            cyc = cyc + 5'd1;
            rst = m_err ? ($urandom % 8 == 0) : ($urandom % 128 == 0);
            vld = ($urandom % 4) != 0;
            if (g_pos == 0) g_len = ($urandom % 10 == 0) ? 5 : int'($urandom_range(1, 4));
            hd = (g_pos == 0);
            tl = (g_pos == g_len - 1);
            if ($urandom % 25 == 0) begin
                hd = $urandom % 2;
                tl = $urandom % 2;
            end
            src = 2'($urandom);
            ts = cyc - 5'($urandom_range(0, 31));
            acc = vld && !m_drain && !rst;
            do_cycle(rst, vld, hd, tl, src, ts, cyc);
            if (rst) g_pos = 0;
            else if (acc) begin
                g_pos++;
                if (tl || g_pos >= g_len) g_pos = 0;
            end
        end

        // Saturation of latency_sum and wrap of packets_received with latency-31 packets
        do_cycle(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2200; i++) begin
            cyc = cyc + 5'd1;
            do_cycle(0, 1, 1, 1, 2'(i), cyc + 5'd1, cyc);
            cyc = cyc + 5'd1;
            do_cycle(0, 1, 1, 1, 2'(i), cyc, cyc);
        end
        chk("sat_sum", 32'(latency_sum), 32'hFFFF);
        chk("sat_pkts", 32'(packets_received), 32'(2200 % 256));
        chk("sat_lat", 32'(last_latency), 31);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
